// File: rtl/fifo2axi_bridge_pkg.sv
// Shared types, AXI constants and 4 KB boundary helper for the FIFO-to-AXI4 write bridge.
package fifo2axi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AW     = 2'd1,
    ST_W      = 2'd2,
    ST_WAIT_B = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_BYTES = 4096;

  // Beats of 2**bytes_lg2 bytes left before the next 4 KB boundary.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo,
                                              input int unsigned bytes_lg2);
    logic [12:0] bytes_left;
    bytes_left = 13'(BOUNDARY_BYTES) - {1'b0, addr_lo};
    return bytes_left >> bytes_lg2;
  endfunction

endpackage

// File: rtl/fifo2axi_burst_calc.sv
// Burst size = min(remaining, MAX_BURST, beats to 4 KB boundary); awlen = size - 1.
module fifo2axi_burst_calc
  import fifo2axi_bridge_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BYTES_LG2 = 4
) (
  input  logic [11:0]          addr_lo,
  input  logic [CNT_WIDTH-1:0] remaining,
  output logic [8:0]           size,
  output logic [7:0]           len
);

  logic [12:0] to_4k;

  always_comb begin
    to_4k = beats_to_4k(addr_lo, BYTES_LG2);
    size  = 9'(MAX_BURST);
    if (13'(size) > to_4k) size = 9'(to_4k);
    if (32'(size) > 32'(remaining)) size = 9'(remaining);
    len = (size == 9'd0) ? 8'd0 : 8'(size - 9'd1);
  end

endmodule

// File: rtl/fifo2axi_wr_bridge.sv
// FIFO-to-AXI4 write bridge: splits a command into INCR bursts, streams FIFO beats, tracks B responses.
module fifo2axi_wr_bridge
  import fifo2axi_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned AWID_VALUE      = 0,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CNT_WIDTH-1:0]    cmd_beats,
  output logic                    done,
  output logic                    err,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned BYTES_LG2 = $clog2(BYTES);
  localparam int unsigned OUT_W     = 4;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d, rem_left;
  logic [8:0]            size_q, calc_size;
  logic [7:0]            len_q, calc_len, beat_q;
  logic [OUT_W-1:0]      out_q, out_after_b;
  logic                  cmd_ready_q, done_q, err_q;
  logic                  cmd_hs, aw_hs, w_hs, wl_hs, b_hs;
  logic                  unused_bid;

  assign unused_bid  = ^bid;
  assign cmd_hs      = cmd_valid & cmd_ready_q;
  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign wl_hs       = w_hs & wlast;
  assign b_hs        = bvalid & bready;
  assign rem_left    = rem_q - CNT_WIDTH'(size_q);
  assign out_after_b = out_q - OUT_W'(b_hs);

  // Sized from the next address/count so len_q is valid in the first AW cycle.
  fifo2axi_burst_calc #(
    .CNT_WIDTH (CNT_WIDTH),
    .MAX_BURST (MAX_BURST),
    .BYTES_LG2 (BYTES_LG2)
  ) u_burst_calc (
    .addr_lo   (addr_d[11:0]),
    .remaining (rem_d),
    .size      (calc_size),
    .len       (calc_len)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_hs && cmd_beats != '0) state_d = ST_AW;
      ST_AW:     if (awready) state_d = ST_W;
      ST_W: begin
        if (wl_hs) begin
          if (rem_left == '0)                              state_d = ST_WAIT_B;
          else if (out_after_b < OUT_W'(MAX_OUTSTANDING)) state_d = ST_AW;
          else                                             state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (rem_q != '0) begin
          if (b_hs) state_d = ST_AW;
        end else if (out_after_b == '0) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    fifo_rd_en = 1'b0;
    bready     = (out_q != '0);
    case (state_q)
      ST_AW: awvalid = 1'b1;
      ST_W: begin
        wvalid     = ~fifo_empty;
        wlast      = (beat_q == len_q);
        fifo_rd_en = wvalid & wready;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (cmd_hs) begin
      addr_d = cmd_addr & ~LOW_MASK;
      rem_d  = cmd_beats;
    end else if (wl_hs) begin
      addr_d = addr_q + (ADDR_WIDTH'(size_q) << BYTES_LG2);
      rem_d  = rem_left;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      rem_q       <= '0;
      size_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      out_q       <= '0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      size_q      <= calc_size;
      len_q       <= calc_len;
      cmd_ready_q <= (state_d == ST_IDLE);
      done_q      <= (cmd_hs && cmd_beats == '0) ||
                     (state_q != ST_IDLE && state_d == ST_IDLE);
      if (aw_hs)     beat_q <= '0;
      else if (w_hs) beat_q <= beat_q + 8'd1;
      case ({aw_hs, b_hs})
        2'b10:   out_q <= out_q + OUT_W'(1);
        2'b01:   out_q <= out_q - OUT_W'(1);
        default: out_q <= out_q;
      endcase
      // err is sticky for the whole command, cleared only by the next accepted one.
      if (cmd_hs)                              err_q <= 1'b0;
      else if (b_hs && bresp != AXI_RESP_OKAY) err_q <= 1'b1;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign awid      = ID_WIDTH'(AWID_VALUE);
  assign awaddr    = addr_q;
  assign awlen     = len_q;
  assign awsize    = 3'(BYTES_LG2);
  assign awburst   = AXI_BURST_INCR;
  assign wdata     = fifo_rd_data;
  assign wstrb     = '1;

endmodule

// File: tb/tb_fifo2axi_wr_bridge.sv
// Scoreboard bench: burst plan, FIFO contents and responses are queued at issue; a monitor checks DUT traffic.
module tb_fifo2axi_wr_bridge;

  localparam int DW   = 128;
  localparam int AWD  = 32;
  localparam int IDW  = 4;
  localparam int MAXB = 16;
  localparam int MAXO = 2;
  localparam int CW   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [AWD-1:0] cmd_addr = '0;
  logic [CW-1:0]  cmd_beats = '0;
  logic done, err;
  logic fifo_empty = 1'b1, fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic [IDW-1:0] awid;
  logic [AWD-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic wlast, wvalid, wready = 1'b0;
  logic [IDW-1:0] bid = '0;
  logic [1:0] bresp = '0;
  logic bvalid = 1'b0, bready;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;

  aw_t           exp_aw[$];
  logic [1:0]    resp_plan[$];
  logic [1:0]    b_pend[$];
  logic          exp_done_q[$];
  logic [DW-1:0] fifo_data[$];
  int            burst_len[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, aw_cnt = 0, w_cnt = 0;
  bit bp = 1'b0, b_en = 1'b1;

  fifo2axi_wr_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .ID_WIDTH(IDW), .AWID_VALUE(0),
    .MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .done(done), .err(err),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  function automatic void check(input bit ok, input string name,
                                input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Slave and FIFO environment, driven on the falling edge.
  always @(negedge clock) begin
    awready      = bp ? ($urandom_range(0, 9) < 7) : 1'b1;
    wready       = bp ? ($urandom_range(0, 9) < 7) : 1'b1;
    fifo_empty   = (bp && $urandom_range(0, 3) == 0) || fifo_data.size() == 0;
    fifo_rd_data = (fifo_data.size() != 0) ? fifo_data[0] : '0;
    bvalid       = b_en && b_pend.size() != 0 && (!bp || $urandom_range(0, 9) < 6);
    bresp        = (b_pend.size() != 0) ? b_pend[0] : 2'b00;
  end

  bit rst_chk = 1'b0, exp_awv_next = 1'b0, exp_done_next = 1'b0, err_clr_next = 1'b0;
  bit prev_stall = 1'b0, wl;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen;
  int outst = 0, beat = 0;
  aw_t a;
  logic e;

  // Monitor: samples settled signals; handshakes seen here complete at the next rising edge.
  always @(negedge clock) begin
    #1;
    if (reset) begin
      exp_aw.delete(); resp_plan.delete(); b_pend.delete();
      exp_done_q.delete(); fifo_data.delete(); burst_len.delete();
      outst = 0; beat = 0;
      exp_awv_next = 0; exp_done_next = 0; err_clr_next = 0; prev_stall = 0;
      rst_chk = 1;
    end else begin
      if (rst_chk) begin
        check({awvalid, wvalid, wlast, bready, fifo_rd_en, done, err, cmd_ready, awaddr, awlen} == '0,
              "reset_values",
              128'({awvalid, wvalid, wlast, bready, fifo_rd_en, done, err, cmd_ready, awaddr, awlen}), 128'(0));
        rst_chk = 0;
      end
      if (exp_awv_next) check(awvalid, "awvalid_latency", 128'(awvalid), 128'(1));
      if (exp_done_next || done) check(done == exp_done_next, "done_timing", 128'(done), 128'(exp_done_next));
      if (err_clr_next) check(!err, "err_cleared", 128'(err), 128'(0));
      exp_awv_next = 0; exp_done_next = 0; err_clr_next = 0;

      if (done) begin
        done_cnt++;
        check(cmd_ready, "ready_at_done", 128'(cmd_ready), 128'(1));
        if (exp_done_q.size() == 0) check(1'b0, "done_unexpected", 128'(done), 128'(0));
        else begin
          e = exp_done_q.pop_front();
          check(err == e, "err_at_done", 128'(err), 128'(e));
        end
      end

      if (prev_stall)
        check(awvalid && awaddr == prev_awaddr && awlen == prev_awlen, "aw_stable",
              128'({awvalid, awaddr, awlen}), 128'({1'b1, prev_awaddr, prev_awlen}));
      prev_stall  = awvalid && !awready;
      prev_awaddr = awaddr;
      prev_awlen  = awlen;

      check(bready == (outst > 0), "bready", 128'(bready), 128'(outst > 0));
      check(fifo_rd_en == (wvalid && wready) && !(fifo_empty && wvalid), "rd_en",
            128'({fifo_rd_en, wvalid}), 128'({wvalid && wready, !fifo_empty && wvalid}));

      if (cmd_valid && cmd_ready) begin
        err_clr_next = 1;
        if (cmd_beats == 0) exp_done_next = 1;
        else                exp_awv_next  = 1;
      end

      if (awvalid && awready) begin
        aw_cnt++;
        outst++;
        check(outst <= MAXO, "outstanding_limit", 128'(outst), 128'(MAXO));
        check(awsize == 3'd4 && awburst == 2'b01 && awid == '0, "aw_attrs",
              128'({awid, awsize, awburst}), 128'({4'd0, 3'd4, 2'b01}));
        if (exp_aw.size() == 0) check(1'b0, "aw_unexpected", 128'(awaddr), 128'(0));
        else begin
          a = exp_aw.pop_front();
          check(awaddr == a.addr && awlen == a.len, "aw_addr_len", 128'({awaddr, awlen}), 128'(a));
          burst_len.push_back(int'(a.len) + 1);
        end
      end

      wl = 0;
      if (wvalid && wready) begin
        w_cnt++;
        if (fifo_data.size() == 0 || burst_len.size() == 0) check(1'b0, "w_unexpected", wdata, 128'(0));
        else begin
          check(wdata == fifo_data[0] && wstrb == '1, "wdata", wdata, fifo_data[0]);
          void'(fifo_data.pop_front());
          beat++;
          wl = (beat == burst_len[0]);
          check(wlast == wl, "wlast", 128'(wlast), 128'(wl));
          if (wl) begin
            void'(burst_len.pop_front());
            beat = 0;
            b_pend.push_back((resp_plan.size() != 0) ? resp_plan.pop_front() : 2'b00);
          end
        end
      end

      if (bvalid && bready) begin
        void'(b_pend.pop_front());
        outst--;
      end
      if (wl && exp_aw.size() != 0 && outst < MAXO) exp_awv_next = 1;
      if (bvalid && bready && outst == 0 && exp_aw.size() == 0 && burst_len.size() == 0)
        exp_done_next = 1;
    end
  end

  // Reference plan: split into bursts by remaining, MAX_BURST and 4 KB boundary; then hand over the command.
  task automatic issue(input logic [31:0] addr, input int n, input int bad, input bit rnd);
    logic [31:0] ad;
    int rem, sz, to4k, idx, k;
    bit any;
    logic [1:0] r;
    ad = addr & ~32'hF; rem = n; idx = 0; any = 0;
    while (rem > 0) begin
      to4k = (4096 - int'(ad % 4096)) / 16;
      sz = rem;
      if (sz > MAXB) sz = MAXB;
      if (sz > to4k) sz = to4k;
      exp_aw.push_back('{ad, 8'(sz - 1)});
      r = (idx == bad || (rnd && $urandom_range(0, 7) == 0)) ? 2'b10 : 2'b00;
      any |= (r != 2'b00);
      resp_plan.push_back(r);
      ad += 32'(sz * 16); rem -= sz; idx++;
    end
    exp_done_q.push_back(any);
    for (int i = 0; i < n; i++) fifo_data.push_back({$urandom, $urandom, $urandom, $urandom});
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_beats = CW'(n);
    #1;
    k = 0;
    while (!cmd_ready && k < 200) begin @(negedge clock); #1; k++; end
    if (k >= 200) check(1'b0, "cmd_ready_timeout", 128'(cmd_ready), 128'(1));
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int start, k;
    start = done_cnt; k = 0;
    while (done_cnt == start && k < limit) begin @(negedge clock); #2; k++; end
    check(done_cnt != start, "done_timeout", 128'(done_cnt), 128'(start + 1));
  endtask

  initial begin
    int start, k;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #2;
    check(cmd_ready, "ready_after_reset", 128'(cmd_ready), 128'(1));

    issue(32'h1000, 16, -1, 0); wait_done(500);
    issue(32'h1000, 40, -1, 0); wait_done(500);
    issue(32'h1FC0, 10, -1, 0); wait_done(500);
    issue(32'h1234, 0, -1, 0);  wait_done(50);

    // B held off: only MAX_OUTSTANDING bursts may go out; second B reports SLVERR.
    b_en = 1'b0;
    start = aw_cnt;
    issue(32'h0, 64, 1, 0);
    repeat (60) @(negedge clock);
    #2;
    check(aw_cnt == start + 2 && !awvalid, "third_aw_blocked", 128'({aw_cnt - start, awvalid}), 128'({32'd2, 1'b0}));
    b_en = 1'b1;
    wait_done(1000);
    issue(32'h1000, 16, -1, 0); wait_done(500);

    bp = 1'b1;
    repeat (12) begin
      issue($urandom & 32'h0003_FFFF, $urandom_range(0, 60), -1, 1);
      wait_done(3000);
    end
    bp = 1'b0;

    // Reset while the fifth beat of a 16-beat burst is on the bus.
    start = w_cnt; k = 0;
    issue(32'h3000, 16, -1, 0);
    while (w_cnt - start < 4 && k < 100) begin @(negedge clock); #2; k++; end
    check(w_cnt - start == 4, "reached_beat5", 128'(w_cnt - start), 128'(4));
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #2;
    check(cmd_ready, "ready_after_midreset", 128'(cmd_ready), 128'(1));
    issue(32'h3000, 16, -1, 0); wait_done(500);

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
